axis_frame_checker: RTL and testbench

- AXI4-Stream sink that terminates the generator → FIFO path in the example top.
- Consumes frames of FRAME_BEATS beats and throttles tready with a programmable rotating pattern.
- Checks data, tkeep, tuser and tlast framing against the generator's pattern.
- Exposes frame and error counters plus sticky error flags for testbench $display and waveform inspection.

---
 rtl/axis_frame_checker.sv | 163 ++++++++++++++++
 tb/tb_axis_frame_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axis_frame_checker
// Description : AXI4-Stream sink that throttles tready with a rotating mask
//               and checks data/tkeep/tuser/tlast framing of incoming frames.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_checker #(
    parameter int         DATA_W        = 32,
    parameter int         KEEP_W        = DATA_W / 8,
    parameter int         USER_W        = 1,
    parameter int         FRAME_BEATS   = 8,
    parameter logic [7:0] READY_PATTERN = 8'hFF,
    parameter int         CNT_W         = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              clear,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_frame_cnt,
    output logic [3:0]        err_flags,
    output logic [15:0]       beat_idx
);

    localparam logic [15:0]       c_last_idx = 16'(FRAME_BEATS - 1);
    localparam logic [15:0]       c_idx_max  = 16'hFFFF;
    localparam logic [15:0]       c_idx_one  = 16'd1;
    localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] c_data_one = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_IN_FRAME = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_pattern;
    logic               r_tready;
    logic [DATA_W-1:0]  r_exp_data;
    logic [DATA_W-1:0]  w_exp_data_next;
    logic [15:0]        r_beat_idx;
    logic [15:0]        w_beat_idx_next;
    logic               r_frame_err;
    logic               w_frame_err_next;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   w_frame_cnt_next;
    logic [CNT_W-1:0]   r_err_frame_cnt;
    logic [CNT_W-1:0]   w_err_frame_cnt_next;
    logic [3:0]         r_err_flags;
    logic [3:0]         w_err_flags_next;
    logic               r_frame_done;
    logic               w_frame_done_next;

    logic               w_hs;
    logic               w_data_err;
    logic               w_keep_err;
    logic               w_user_err;
    logic               w_len_err;
    logic [3:0]         w_errs;
    logic               w_any_err;

    // Throttle pattern free-runs; clear deliberately leaves it alone.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pattern <= READY_PATTERN;
            r_tready  <= 1'b0;
        end else begin
            r_pattern <= {r_pattern[0], r_pattern[7:1]};
            r_tready  <= r_pattern[0];
        end
    end

    assign w_hs       = s_axis_tvalid & r_tready;
    assign w_data_err = (s_axis_tdata != r_exp_data);
    assign w_keep_err = (s_axis_tkeep != {KEEP_W{1'b1}});
    assign w_user_err = s_axis_tuser[0] != (r_state == S_IDLE);
    assign w_len_err  = s_axis_tlast ? (r_beat_idx != c_last_idx)
                                     : (r_beat_idx >= c_last_idx);
    assign w_errs     = {w_len_err, w_user_err, w_keep_err, w_data_err};
    assign w_any_err  = |w_errs;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state         <= S_IDLE;
            r_exp_data      <= '0;
            r_beat_idx      <= '0;
            r_frame_err     <= 1'b0;
            r_frame_cnt     <= '0;
            r_err_frame_cnt <= '0;
            r_err_flags     <= '0;
            r_frame_done    <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_exp_data      <= w_exp_data_next;
            r_beat_idx      <= w_beat_idx_next;
            r_frame_err     <= w_frame_err_next;
            r_frame_cnt     <= w_frame_cnt_next;
            r_err_frame_cnt <= w_err_frame_cnt_next;
            r_err_flags     <= w_err_flags_next;
            r_frame_done    <= w_frame_done_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_exp_data_next      = r_exp_data;
        w_beat_idx_next      = r_beat_idx;
        w_frame_err_next     = r_frame_err;
        w_frame_cnt_next     = r_frame_cnt;
        w_err_frame_cnt_next = r_err_frame_cnt;
        w_err_flags_next     = r_err_flags;
        w_frame_done_next    = 1'b0;

        if (clear) begin
            // Takes priority over a coincident tlast handshake.
            w_state_next         = S_IDLE;
            w_exp_data_next      = '0;
            w_beat_idx_next      = '0;
            w_frame_err_next     = 1'b0;
            w_frame_cnt_next     = '0;
            w_err_frame_cnt_next = '0;
            w_err_flags_next     = '0;
        end else if (w_hs) begin
            w_err_flags_next = r_err_flags | w_errs;
            // Resync to the source so one bad word yields a bounded burst of errors.
            w_exp_data_next  = s_axis_tdata + c_data_one;
            if (s_axis_tlast) begin
                w_state_next      = S_IDLE;
                w_beat_idx_next   = '0;
                w_frame_err_next  = 1'b0;
                w_frame_done_next = 1'b1;
                w_frame_cnt_next  = r_frame_cnt + c_cnt_one;
                if (r_frame_err || w_any_err) begin
                    w_err_frame_cnt_next = r_err_frame_cnt + c_cnt_one;
                end
            end else begin
                w_state_next     = S_IN_FRAME;
                w_frame_err_next = r_frame_err | w_any_err;
                if (r_beat_idx != c_idx_max) begin
                    w_beat_idx_next = r_beat_idx + c_idx_one;
                end
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;
    assign err_frame_cnt = r_err_frame_cnt;
    assign err_flags     = r_err_flags;
    assign beat_idx      = r_beat_idx;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_checker
// Description : Self-checking bench for axis_frame_checker with a behavioural
//               frame model, directed scenarios and randomized frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_checker;

    localparam int         DATA_W      = 32;
    localparam int         KEEP_W      = 4;
    localparam int         USER_W      = 1;
    localparam int         FRAME_BEATS = 8;
    localparam int         CNT_W       = 16;
    localparam logic [7:0] PAT         = 8'b1011_0010;

    logic              aclk;
    logic              aresetn;
    logic              clear;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic [USER_W-1:0] s_axis_tuser;
    logic              s_axis_tlast;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_frame_cnt;
    logic [3:0]        err_flags;
    logic [15:0]       beat_idx;

    axis_frame_checker #(
        .DATA_W        (DATA_W),
        .KEEP_W        (KEEP_W),
        .USER_W        (USER_W),
        .FRAME_BEATS   (FRAME_BEATS),
        .READY_PATTERN (PAT),
        .CNT_W         (CNT_W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .clear         (clear),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_frame_cnt (err_frame_cnt),
        .err_flags     (err_flags),
        .beat_idx      (beat_idx)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: edges since reset select the ready bit; each
    // accepted beat is judged against the frame rules directly.
    int          m_edges;
    bit          m_tready;
    logic [31:0] m_exp;
    int          m_idx;
    bit          m_ferr;
    int          m_fcnt;
    int          m_efcnt;
    logic [3:0]  m_flags;
    bit          m_done;
    bit          m_hs;
    logic [3:0]  m_e;

    initial forever begin
        @(posedge aclk or negedge aresetn);
        if (!aresetn) begin
            m_edges = 0; m_tready = 0; m_exp = 0; m_idx = 0; m_ferr = 0;
            m_fcnt = 0; m_efcnt = 0; m_flags = 0; m_done = 0;
        end else begin
            m_hs = s_axis_tvalid && m_tready;
            m_e  = 4'b0;
            if (m_hs) begin
                m_e[0] = (s_axis_tdata != m_exp);
                m_e[1] = (s_axis_tkeep != 4'hF);
                m_e[2] = (s_axis_tuser[0] != (m_idx == 0));
                m_e[3] = s_axis_tlast ? (m_idx != FRAME_BEATS - 1) : (m_idx >= FRAME_BEATS - 1);
            end
            m_done = 0;
            if (clear) begin
                m_exp = 0; m_idx = 0; m_ferr = 0; m_fcnt = 0; m_efcnt = 0; m_flags = 0;
            end else if (m_hs) begin
                m_flags = m_flags | m_e;
                m_exp   = s_axis_tdata + 32'd1;
                if (s_axis_tlast) begin
                    m_done = 1;
                    m_fcnt = (m_fcnt + 1) % 65536;
                    if (m_ferr || (m_e != 0)) m_efcnt = (m_efcnt + 1) % 65536;
                    m_ferr = 0;
                    m_idx  = 0;
                end else begin
                    m_ferr = m_ferr || (m_e != 0);
                    if (m_idx < 65535) m_idx = m_idx + 1;
                end
            end
            m_tready = PAT[m_edges % 8];
            m_edges  = m_edges + 1;
        end
    end

    bit cmp_en = 0;
    initial forever begin
        @(negedge aclk);
        if (aresetn && cmp_en) begin
            check("tready",        s_axis_tready, m_tready);
            check("frame_done",    frame_done,    m_done);
            check("frame_cnt",     frame_cnt,     m_fcnt[15:0]);
            check("err_frame_cnt", err_frame_cnt, m_efcnt[15:0]);
            check("err_flags",     err_flags,     m_flags);
            check("beat_idx",      beat_idx,      m_idx[15:0]);
            if (frame_done) n_done++;
        end
    end

    // All drivers start at posedge+1 and return at posedge+1.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic u,
                             input logic l, input logic c);
        bit hs;
        int n;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        clear         = c;
        hs = 0;
        n  = 0;
        while (!hs && n < 64) begin
            @(negedge aclk);
            hs = s_axis_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        clear         = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: actual no handshake required handshake within 64 cycles");
        end
    endtask

    task automatic send_frame(input logic [31:0] base, input int nb);
        for (int i = 0; i < nb; i++)
            send_beat(base + i, 4'hF, (i == 0), (i == nb - 1), 1'b0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    logic [7:0]  rsamp;
    int          d0;
    logic [31:0] g;
    logic [31:0] d;
    logic [3:0]  k;
    logic        u;
    int          flen;
    int          cbeat;

    initial begin
        aresetn = 0; clear = 0; s_axis_tdata = 0; s_axis_tkeep = 0;
        s_axis_tuser = 0; s_axis_tlast = 0; s_axis_tvalid = 0;
        repeat (3) @(posedge aclk);
        #3 aresetn = 1;
        #1;
        check("rst_tready",    s_axis_tready, 1'b0);
        check("rst_frame_cnt", frame_cnt,     16'd0);
        check("rst_flags",     err_flags,     4'd0);
        check("rst_beat_idx",  beat_idx,      16'd0);
        cmp_en = 1;

        for (int i = 0; i < 8; i++) begin
            @(posedge aclk);
            #1;
            rsamp[i] = s_axis_tready;
        end
        check("ready_pattern", rsamp, 8'b1011_0010);

        // Three clean frames
        d0 = n_done;
        send_frame(32'd0, 8);
        send_frame(32'd8, 8);
        send_frame(32'd16, 8);
        @(negedge aclk); #1;
        check("clean_frame_cnt", frame_cnt,     16'd3);
        check("clean_err_cnt",   err_frame_cnt, 16'd0);
        check("clean_flags",     err_flags,     4'd0);
        check("clean_done_cnt",  n_done - d0,   3);
        @(posedge aclk); #1;

        // Corrupt word in beat 3, resync on beat 4
        pulse_clear();
        for (int i = 0; i < 8; i++)
            send_beat((i == 3) ? 32'hDEAD : i, 4'hF, (i == 0), (i == 7), 1'b0);
        check("data_flags",   err_flags,     4'b0001);
        check("data_err_cnt", err_frame_cnt, 16'd1);
        send_frame(32'd8, 8);
        check("data_frame_cnt", frame_cnt,     16'd2);
        check("data_err_cnt2",  err_frame_cnt, 16'd1);

        // Early tlast then a normal frame
        pulse_clear();
        send_frame(32'd0, 6);
        check("len_flags",  err_flags, 4'b1000);
        check("len_idx0",   beat_idx,  16'd0);
        send_frame(32'd6, 8);
        check("len_frame_cnt", frame_cnt,     16'd2);
        check("len_err_cnt",   err_frame_cnt, 16'd1);
        check("len_idx1",      beat_idx,      16'd0);

        // Bad tkeep and misplaced tuser, then clear
        pulse_clear();
        for (int i = 0; i < 8; i++)
            send_beat(i, (i == 2) ? 4'h7 : 4'hF, (i == 0) || (i == 4), (i == 7), 1'b0);
        check("ku_flags",   err_flags,     4'b0110);
        check("ku_err_cnt", err_frame_cnt, 16'd1);
        pulse_clear();
        check("clr_frame_cnt", frame_cnt,     16'd0);
        check("clr_err_cnt",   err_frame_cnt, 16'd0);
        check("clr_flags",     err_flags,     4'd0);

        // Asynchronous reset in the middle of a frame
        send_frame(32'd0, 8);
        for (int i = 0; i < 5; i++)
            send_beat(32'd8 + i, 4'hF, (i == 0), 1'b0, 1'b0);
        #2 aresetn = 0;
        #1;
        check("arst_tready",    s_axis_tready, 1'b0);
        check("arst_beat_idx",  beat_idx,      16'd0);
        check("arst_frame_cnt", frame_cnt,     16'd0);
        check("arst_done",      frame_done,    1'b0);
        @(posedge aclk);
        #3 aresetn = 1;
        @(posedge aclk); #1;
        send_frame(32'd0, 8);
        check("arst_clean_cnt",   frame_cnt, 16'd1);
        check("arst_clean_flags", err_flags, 4'd0);

        // Randomized frames with sporadic corruption, bad lengths and clears
        g = 32'd0;
        for (int f = 0; f < 150; f++) begin
            flen  = ($urandom % 5 == 0) ? int'($urandom_range(5, 10)) : FRAME_BEATS;
            cbeat = ($urandom % 20 == 0) ? int'($urandom_range(0, flen - 1)) : -1;
            for (int i = 0; i < flen; i++) begin
                d = ($urandom % 20 == 0) ? $urandom : g;
                k = ($urandom % 25 == 0) ? 4'($urandom) : 4'hF;
                u = (i == 0) ^ ($urandom % 30 == 0);
                send_beat(d, k, u, (i == flen - 1), (i == cbeat));
                g = (i == cbeat) ? 32'd0 : d + 32'd1;
                idle($urandom % 3);
            end
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
